development_stage_sequencer: RTL

//  Sequences the mimosa's development stage from the inc/dec/fast/setval requests of the

---
 rtl/development_stage_sequencer_if.sv | 28 ++
 rtl/development_stage_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/development_stage_sequencer_if.sv
// Regulator <-> development stage sequencer bundle: request strobes toward the
// sequencer, stage/progress status back to the regulator and display logic.
interface development_stage_sequencer_if #(
  parameter int STAGE_W = 3,
  parameter int PROG_W  = 8
);
  logic               tick;
  logic               inc;
  logic               dec;
  logic               fast;
  logic               setval;
  logic [STAGE_W-1:0] set_stage;
  logic [STAGE_W-1:0] stage;
  logic [PROG_W-1:0]  progress;
  logic               stage_up;
  logic               stage_down;
  logic [1:0]         seq_state;

  modport master (
    output tick, inc, dec, fast, setval, set_stage,
    input  stage, progress, stage_up, stage_down, seq_state
  );

  modport slave (
    input  tick, inc, dec, fast, setval, set_stage,
    output stage, progress, stage_up, stage_down, seq_state
  );
endinterface

// File: rtl/development_stage_sequencer.sv
// Mimosa development stage sequencer: tick-sampled credits/debits move the stage up/down.
// Optional macro DEV_STAGE_SEQ_COOLDOWN_EN adds post-stage-up regression immunity (COOLDOWN).
module development_stage_sequencer #(
  parameter int STAGE_W        = 3,
  parameter int NUM_STAGES     = 6,
  parameter int PROG_W         = 8,
  parameter int BASE_THRESH    = 16,
  parameter int SLOW_DIV       = 4,
  parameter int DEC_DIV        = 8,
  parameter int COOLDOWN_TICKS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  development_stage_sequencer_if.slave bus
);

  localparam int WIDE_W = PROG_W + STAGE_W;
  localparam int SLOW_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int DEC_W  = (DEC_DIV > 1) ? $clog2(DEC_DIV) : 1;
  localparam logic [STAGE_W-1:0] TOP_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [SLOW_W-1:0]  SLOW_LAST = SLOW_W'(SLOW_DIV - 1);
  localparam logic [DEC_W-1:0]   DEC_LAST  = DEC_W'(DEC_DIV - 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 2**STAGE_W || COOLDOWN_TICKS < 1 ||
      BASE_THRESH * (NUM_STAGES - 1) >= 2**PROG_W) begin : g_bad_params
    $error("development_stage_sequencer: inconsistent parameters");
  end

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    COOLDOWN = 2'd1,
    MATURE   = 2'd2
  } seq_state_t;

`ifdef DEV_STAGE_SEQ_COOLDOWN_EN
  localparam int COOL_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_TICKS - 1);
  localparam seq_state_t POST_UP_STATE = COOLDOWN;
  logic [COOL_W-1:0] cool_cnt_q;
`else
  localparam seq_state_t POST_UP_STATE = NORMAL;
`endif

  seq_state_t         state_q;
  logic [STAGE_W-1:0] stage_q;
  logic [PROG_W-1:0]  progress_q;
  logic               stage_up_q;
  logic               stage_down_q;
  logic [SLOW_W-1:0]  slow_cnt_q;
  logic [DEC_W-1:0]   dec_cnt_q;

  // Threshold to leave stage s, evaluated wide enough that it can never wrap.
  function automatic logic [WIDE_W-1:0] thresh_of(input logic [STAGE_W-1:0] s);
    return WIDE_W'(BASE_THRESH) * (WIDE_W'(s) + WIDE_W'(1));
  endfunction

  logic               inc_eff;
  logic               dec_eff;
  logic               slow_hit;
  logic               dec_hit;
  logic               credit;
  logic               debit;
  logic               reach;
  logic [SLOW_W-1:0]  slow_nxt;
  logic [DEC_W-1:0]   dec_nxt;
  logic [WIDE_W-1:0]  half_below;
  logic [STAGE_W-1:0] stage_inc;
  logic [STAGE_W-1:0] set_clamped;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    slow_nxt = '0;
    dec_nxt  = '0;

    // MATURE ignores inc and COOLDOWN ignores dec; an ignored request acts as if low.
    inc_eff  = bus.inc & (state_q != MATURE);
    dec_eff  = bus.dec & (state_q != COOLDOWN);
    slow_hit = (slow_cnt_q == SLOW_LAST);
    dec_hit  = (dec_cnt_q == DEC_LAST);
    credit   = inc_eff & ~dec_eff & (bus.fast | slow_hit);
    debit    = dec_eff & ~inc_eff & dec_hit;

    if (inc_eff && dec_eff) begin
      slow_nxt = slow_cnt_q;
      dec_nxt  = dec_cnt_q;
    end else begin
      if (inc_eff && !bus.fast) slow_nxt = slow_hit ? '0 : slow_cnt_q + SLOW_W'(1);
      if (dec_eff)              dec_nxt  = dec_hit  ? '0 : dec_cnt_q + DEC_W'(1);
    end

    reach       = (WIDE_W'(progress_q) + WIDE_W'(1)) >= thresh_of(stage_q);
    half_below  = thresh_of(stage_q - STAGE_W'(1)) >> 1;
    stage_inc   = stage_q + STAGE_W'(1);
    set_clamped = (bus.set_stage > TOP_STAGE) ? TOP_STAGE : bus.set_stage;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      stage_q      <= '0;
      progress_q   <= '0;
      stage_up_q   <= 1'b0;
      stage_down_q <= 1'b0;
      slow_cnt_q   <= '0;
      dec_cnt_q    <= '0;
`ifdef DEV_STAGE_SEQ_COOLDOWN_EN
      cool_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so later defaults-then-overrides stay race free.
      stage_up_q   <= 1'b0;
      stage_down_q <= 1'b0;
      if (bus.setval) begin
        stage_q    <= set_clamped;
        progress_q <= '0;
        slow_cnt_q <= '0;
        dec_cnt_q  <= '0;
        state_q    <= (set_clamped == TOP_STAGE) ? MATURE : NORMAL;
`ifdef DEV_STAGE_SEQ_COOLDOWN_EN
        cool_cnt_q <= '0;
`endif
      end else if (bus.tick) begin
        slow_cnt_q <= slow_nxt;
        dec_cnt_q  <= dec_nxt;
        if (credit && reach) begin
          stage_q    <= stage_inc;
          progress_q <= '0;
          stage_up_q <= 1'b1;
          state_q    <= (stage_inc == TOP_STAGE) ? MATURE : POST_UP_STATE;
`ifdef DEV_STAGE_SEQ_COOLDOWN_EN
          cool_cnt_q <= '0;
`endif
        end else begin
          if (credit) begin
            progress_q <= progress_q + PROG_W'(1);
          end else if (debit) begin
            if (progress_q != '0) begin
              progress_q <= progress_q - PROG_W'(1);
            end else if (stage_q != '0) begin
              stage_q      <= stage_q - STAGE_W'(1);
              progress_q   <= PROG_W'(half_below);
              stage_down_q <= 1'b1;
              state_q      <= NORMAL;
            end
          end
`ifdef DEV_STAGE_SEQ_COOLDOWN_EN
          if (state_q == COOLDOWN) begin
            if (cool_cnt_q == COOL_LAST) begin
              cool_cnt_q <= '0;
              state_q    <= NORMAL;
            end else begin
              cool_cnt_q <= cool_cnt_q + COOL_W'(1);
            end
          end
`endif
        end
      end
    end
  end

  assign bus.stage      = stage_q;
  assign bus.progress   = progress_q;
  assign bus.stage_up   = stage_up_q;
  assign bus.stage_down = stage_down_q;
  assign bus.seq_state  = state_q;

endmodule
